// File: rtl/multicycle_controller.sv
// multicycle_controller: main control FSM plus ALU and immediate decoders for
// the multicycle RV32I-subset core. The FSM holds only the state register;
// all outputs are decoded combinationally from the current state (Moore),
// except PCWrite, which also depends on the live ALU zero flag for branches.
//
// Optional build macro BNE_EN: when defined, the BEQ state also resolves bne
// (funct3[0]=1 inverts the branch condition). When undefined, funct3 is
// ignored in BEQ and every conditional branch behaves as beq.
//
// Interface: no valid/ready handshakes. The datapath presents op/funct3/
// funct7b5 from the IR (stable from DECODE onward) and zero from the ALU in
// the same cycle; the controller answers with selects/enables in that cycle.
module multicycle_controller #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [6:0]         op,
  input  logic [2:0]         funct3,
  input  logic               funct7b5,
  input  logic               zero,
  output logic               PCWrite,
  output logic               AdrSrc,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic [1:0]         ResultSrc,
  output logic [1:0]         ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [2:0]         ALUControl,
  output logic [1:0]         ImmSrc,
  output logic               RegWrite,
  output logic [STATE_W-1:0] state
);

  // State encodings are fixed so external checkers can decode `state`.
  localparam logic [3:0] FETCH    = 4'd0;
  localparam logic [3:0] DECODE   = 4'd1;
  localparam logic [3:0] MEMADR   = 4'd2;
  localparam logic [3:0] MEMREAD  = 4'd3;
  localparam logic [3:0] MEMWB    = 4'd4;
  localparam logic [3:0] MEMWRITE = 4'd5;
  localparam logic [3:0] EXECR    = 4'd6;
  localparam logic [3:0] ALUWB    = 4'd7;
  localparam logic [3:0] EXECI    = 4'd8;
  localparam logic [3:0] JAL      = 4'd9;
  localparam logic [3:0] BEQ      = 4'd10;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_BRAN  = 7'b1100011;

  logic [3:0] curState;
  logic [3:0] nextState;
  logic       pcUpdate;
  logic       branch;
  logic       irWriteRaw;
  logic       memWriteRaw;
  logic       regWriteRaw;
  logic [1:0] aluOp;
  logic       branchCond;

  // State register; reset forces FETCH immediately, without waiting for clk.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) curState <= FETCH;
    else        curState <= nextState;
  end

  // Next-state decode; unknown opcodes and unused encodings return to FETCH.
  always_comb begin
    nextState = FETCH;
    case (curState)
      FETCH:  nextState = DECODE;
      DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: nextState = MEMADR;
          OP_RTYPE:          nextState = EXECR;
          OP_ITYPE:          nextState = EXECI;
          OP_JAL:            nextState = JAL;
          OP_BRAN:           nextState = BEQ;
          default:           nextState = FETCH;
        endcase
      end
      MEMADR:   nextState = (op == OP_LOAD) ? MEMREAD : MEMWRITE;
      MEMREAD:  nextState = MEMWB;
      MEMWB:    nextState = FETCH;
      MEMWRITE: nextState = FETCH;
      EXECR:    nextState = ALUWB;
      EXECI:    nextState = ALUWB;
      ALUWB:    nextState = FETCH;
      JAL:      nextState = ALUWB;
      BEQ:      nextState = FETCH;
      default:  nextState = FETCH;
    endcase
  end

  // Moore output decode; selects default to 00 and enables to 0.
  always_comb begin
    AdrSrc      = 1'b0;
    ResultSrc   = 2'b00;
    ALUSrcA     = 2'b00;
    ALUSrcB     = 2'b00;
    aluOp       = 2'b00;
    pcUpdate    = 1'b0;
    branch      = 1'b0;
    irWriteRaw  = 1'b0;
    memWriteRaw = 1'b0;
    regWriteRaw = 1'b0;
    case (curState)
      FETCH: begin
        irWriteRaw = 1'b1;
        ALUSrcB    = 2'b10;
        ResultSrc  = 2'b10;
        pcUpdate   = 1'b1;
      end
      DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      MEMREAD: begin
        AdrSrc = 1'b1;
      end
      MEMWB: begin
        ResultSrc   = 2'b01;
        regWriteRaw = 1'b1;
      end
      MEMWRITE: begin
        AdrSrc      = 1'b1;
        memWriteRaw = 1'b1;
      end
      EXECR: begin
        ALUSrcA = 2'b10;
        aluOp   = 2'b10;
      end
      EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        aluOp   = 2'b10;
      end
      ALUWB: begin
        regWriteRaw = 1'b1;
      end
      JAL: begin
        ALUSrcA  = 2'b01;
        ALUSrcB  = 2'b10;
        pcUpdate = 1'b1;
      end
      BEQ: begin
        ALUSrcA = 2'b10;
        aluOp   = 2'b01;
        branch  = 1'b1;
      end
      default: begin
        AdrSrc = 1'b0;
      end
    endcase
  end

  // Branch condition: zero for beq; bne inverts it when BNE_EN is built in.
`ifdef BNE_EN
  assign branchCond = funct3[0] ? ~zero : zero;
`else
  assign branchCond = zero;
`endif

  // Enables are held low while reset is asserted so an abandoned instruction
  // cannot commit anything in the cycle reset arrives.
  assign PCWrite  = reset & (pcUpdate | (branch & branchCond));
  assign IRWrite  = reset & irWriteRaw;
  assign MemWrite = reset & memWriteRaw;
  assign RegWrite = reset & regWriteRaw;

  // ALU decoder: subtract for R-type with funct7b5; I-type never subtracts.
  always_comb begin
    ALUControl = 3'b000;
    case (aluOp)
      2'b00: ALUControl = 3'b000;
      2'b01: ALUControl = 3'b001;
      2'b10: begin
        case (funct3)
          3'b000:  ALUControl = (op[5] & funct7b5) ? 3'b001 : 3'b000;
          3'b010:  ALUControl = 3'b101;
          3'b110:  ALUControl = 3'b011;
          3'b111:  ALUControl = 3'b010;
          default: ALUControl = 3'b000;
        endcase
      end
      default: ALUControl = 3'b000;
    endcase
  end

  // Immediate format from opcode alone, independent of state.
  always_comb begin
    ImmSrc = 2'b00;
    case (op)
      OP_LOAD, OP_ITYPE: ImmSrc = 2'b00;
      OP_STORE:          ImmSrc = 2'b01;
      OP_BRAN:           ImmSrc = 2'b10;
      OP_JAL:            ImmSrc = 2'b11;
      default:           ImmSrc = 2'b00;
    endcase
  end

  // Debug view of the state, zero-extended to STATE_W.
  always_comb begin
    state      = '0;
    state[3:0] = curState;
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Main control FSM plus ALU/immediate decoders for the multicycle RV32I-subset processor that replaces the single-cycle core under `top`.
- Sequences the shared instruction/data memory, the ALU, and the PC/IR/register-file write enables over 3–5 cycles per instruction.
- Sits beside the multicycle datapath inside `top`; the existing store-checking bench (MemWrite/DataAdr/WriteData) still applies unchanged.

Parameters:
- STATE_W, 4, width of the `state` debug output; must be ≥4.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low; 0 = reset asserted
- op  in  7  instruction[6:0], valid from IR after Fetch
- funct3  in  3  instruction[14:12]
- funct7b5  in  1  instruction[30]
- zero  in  1  ALU zero flag, combinational from datapath
- PCWrite  out  1  PC register enable
- AdrSrc  out  1  memory address mux select: 0 = PC, 1 = ALUOut
- MemWrite  out  1  memory write strobe
- IRWrite  out  1  instruction/OldPC register enable
- ResultSrc  out  2  result mux: 00 = ALUOut, 01 = Data, 10 = ALUResult
- ALUSrcA  out  2  ALU A select: 00 = PC, 01 = OldPC, 10 = rs1
- ALUSrcB  out  2  ALU B select: 00 = rs2, 01 = ImmExt, 10 = constant 4
- ALUControl  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- ImmSrc  out  2  00 I, 01 S, 10 B, 11 J
- RegWrite  out  1  register file write enable
- state  out  STATE_W  current state encoding, for debug/verification

Behaviour:
- States and encodings: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, ALUWB=7, EXECI=8, JAL=9, BEQ=10.
- Registered state only; all outputs are combinational (Moore), except PCWrite = PCUpdate | (Branch & zero).
- Reset:
  - reset=0 forces state=FETCH immediately (asynchronous).
  - While reset=0, PCWrite, IRWrite, MemWrite and RegWrite are forced 0.
  - Other outputs take their FETCH values.
- Per-state outputs (unlisted selects = 00, unlisted enables = 0):
  - FETCH:
    - Outputs: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10, PCUpdate=1.
    - Next: DECODE.
  - DECODE:
    - Outputs: ALUSrcA=01, ALUSrcB=01, ALUOp=00.
    - Next by op: 0000011 or 0100011 → MEMADR; 0110011 → EXECR; 0010011 → EXECI; 1101111 → JAL; 1100011 → BEQ; any other op → FETCH.
    - An unsupported op has no side effects.
  - MEMADR:
    - Outputs: ALUSrcA=10, ALUSrcB=01, ALUOp=00.
    - Next: op=0000011 → MEMREAD, else MEMWRITE.
  - MEMREAD: AdrSrc=1, ResultSrc=00 → MEMWB.
  - MEMWB: ResultSrc=01, RegWrite=1 → FETCH.
  - MEMWRITE: AdrSrc=1, MemWrite=1 → FETCH.
  - EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10 → ALUWB.
  - EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10 → ALUWB.
  - ALUWB: ResultSrc=00, RegWrite=1 → FETCH.
  - JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1 → ALUWB.
  - BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1 → FETCH.
- Cycles per instruction: lw 5; sw, R-type, I-ALU and jal 4; beq 3; unsupported op 2.
- ALU decoder (internal 2-bit ALUOp):
  - ALUOp 00 → add; 01 → sub.
  - ALUOp 10, by funct3:
    - 000 → sub if (op[5] & funct7b5), else add.
    - 010 → slt; 110 → or; 111 → and.
    - Any other funct3 → add.
- Immediate decoder from op (independent of state):
  - 0000011, 0010011 → 00; 0100011 → 01; 1100011 → 10; 1101111 → 11; else 00.
- Reset asserted mid-instruction: the instruction is abandoned and no enable fires in that cycle; the first cycle after release is FETCH.
- MemWrite is asserted in exactly one cycle per sw and never in any other state.

Optional Feature:
- Macro: BNE_EN.
- When defined:
  - The BEQ state also handles bne (op 1100011, funct3 001).
  - The branch condition becomes (funct3[0] ? ~zero : zero), gated by Branch.
- When undefined:
  - funct3 is ignored in BEQ; the condition is zero only, so bne behaves as beq.

Test Plan:
- Reset held low for 3 cycles, then released → state=0 on the first edge, with PCWrite=IRWrite=MemWrite=RegWrite=0 during reset; after release, FETCH asserts IRWrite=1, PCWrite=1, ResultSrc=10.
- op=0000011 (lw) → state trace 0,1,2,3,4,0; RegWrite=1 only in state 4 with ResultSrc=01; AdrSrc=1 in state 3.
- op=0100011 (sw) → trace 0,1,2,5,0; MemWrite=1 for exactly one cycle; ImmSrc=01.
- op=0110011, funct3=000, funct7b5=1 → ALUControl=001 in EXECR; with funct7b5=0 → 000; funct3=111 → 010; funct3=010 → 101.
- op=1100011 with zero=1 → PCWrite=1 in BEQ; zero=0 → PCWrite=0; then back to FETCH (3 cycles). With BNE_EN and funct3=001, the results invert.
- op=0000000 → trace 0,1,0 with no write enable. Reset dropped while in MEMWRITE → MemWrite=0 immediately, state=0. Full `top` program stores 25 to address 100 → bench prints "Simulation succeeded".
